four_bit_adder: RTL and testbench



---
 rtl/four_bit_adder_pkg.sv | 9 +
 rtl/four_bit_adder_add_sub_core.sv | 27 ++
 rtl/four_bit_adder.sv | 56 +++++
 tb/tb_four_bit_adder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/four_bit_adder_pkg.sv
// Shared constants for the registered adder/subtractor slice.
package four_bit_adder_pkg;

    localparam int unsigned WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/four_bit_adder_add_sub_core.sv
// Combinational two's-complement add/subtract with carry and signed overflow.
module add_sub_core
    import four_bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = four_bit_adder_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff    = (sub == OP_SUB) ? ~b : b;
        // Subtract is A + ~B + 1, so sub doubles as the carry-in.
        full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum      = full[WIDTH-1:0];
        carry    = full[WIDTH];
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/four_bit_adder.sv
// Registered adder/subtractor: one-cycle latency, result and flags hold while idle.
module four_bit_adder
    import four_bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = four_bit_adder_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    add_sub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (a),
        .b        (b),
        .sub      (sub),
        .sum      (sum),
        .carry    (carry),
        .overflow (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            negative  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= sum;
                carry_out <= carry;
                overflow  <= ovf;
                zero      <= (sum == '0);
                negative  <= sum[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed self-checking bench for four_bit_adder.
module tb_four_bit_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic       out_valid;
    logic [3:0] result;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       negative;

    int n_checks = 0;
    int n_fail   = 0;

    four_bit_adder #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check every output against {valid, result, carry, overflow, zero, negative}.
    task automatic chk_all(input string tag, input logic v, input logic [3:0] r,
                           input logic c, input logic o, input logic z, input logic n);
        chk({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, v});
        chk({tag, ".result"},    result,            r);
        chk({tag, ".carry_out"}, {3'b0, carry_out}, {3'b0, c});
        chk({tag, ".overflow"},  {3'b0, overflow},  {3'b0, o});
        chk({tag, ".zero"},      {3'b0, zero},      {3'b0, z});
        chk({tag, ".negative"},  {3'b0, negative},  {3'b0, n});
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the capturing edge.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                        input logic tv);
        a        = ta;
        b        = tb_;
        sub      = ts;
        in_valid = tv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'h0;
        b        = 4'h0;
        sub      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back operations, one per cycle.
        step(4'b0101, 4'b1000, 1'b1, 1'b1);
        chk_all("sub_5_m8", 1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4'b0100, 4'b1001, 1'b0, 1'b1);
        chk_all("add_4_p9", 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b1111, 4'b0001, 1'b0, 1'b1);
        chk_all("add_wrap", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'b0111, 4'b0111, 1'b1, 1'b1);
        chk_all("sub_eq", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'b0111, 4'b0001, 1'b0, 1'b1);
        chk_all("add_ovf", 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Idle cycles with junk inputs: valid drops, everything else holds.
        step(4'b1010, 4'b0011, 1'b1, 1'b0);
        chk_all("idle1", 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk_all("idle2", 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);

        step(4'b0011, 4'b0100, 1'b0, 1'b1);
        chk_all("add_3_p4", 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, checked before the next clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1000, 4'b0001, 1'b1, 1'b1);
        chk_all("sub_m8_1", 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 4'b0011, 1'b1, 1'b1);
        chk_all("sub_borrow", 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
